// File: rtl/pattern_prbs_generator_pkg.sv
// Shared definitions for the pattern/PRBS stimulus generator: FSM states,
// PRBS-15 taps and the byte-wide LFSR advance function.
package prbs_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        PRBS,
        DONE
    } gen_state_e;

    localparam int unsigned PRBS15_TAP_HI = 14;
    localparam int unsigned PRBS15_TAP_LO = 13;

    typedef struct packed {
        logic [14:0] next_lfsr;
        logic [7:0]  data;
    } prbs_step_t;

    // Eight serial steps; the first feedback bit lands in data[7].
    function automatic prbs_step_t prbs15_byte(input logic [14:0] lfsr);
        logic [14:0] r;
        logic [7:0]  b;
        logic        fb;
        r = lfsr;
        b = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = r[PRBS15_TAP_HI] ^ r[PRBS15_TAP_LO];
            r  = {r[13:0], fb};
            b  = {b[6:0], fb};
        end
        return '{next_lfsr: r, data: b};
    endfunction

endpackage

// File: rtl/pattern_prbs_generator_lfsr.sv
// PRBS-15 register with seed load and one-byte advance; o_byte is the byte
// the next advance would emit.
module prbs15_lfsr
    import prbs_pkg::*;
#(
    parameter logic [14:0] LFSR_SEED = 15'h7FFF
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       i_load,
    input  logic       i_step8,
    output logic [7:0] o_byte
);

    logic [14:0] r_lfsr;
    logic [14:0] w_base;
    prbs_step_t  w_adv;

    // Load and step together emit the seed's byte and leave the register past it.
    assign w_base = i_load ? LFSR_SEED : r_lfsr;
    assign w_adv  = prbs15_byte(w_base);
    assign o_byte = w_adv.data;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_step8) begin
            r_lfsr <= w_adv.next_lfsr;
        end else if (i_load) begin
            r_lfsr <= LFSR_SEED;
        end
    end

endmodule

// File: rtl/pattern_prbs_generator.sv
// Framed stimulus source: n repetitions of PATTERN (MSB byte first) followed
// by prbs_len PRBS-15 bytes, contiguous data_valid, then a one-cycle done.
module pattern_prbs_generator
    import prbs_pkg::*;
#(
    parameter logic [31:0] PATTERN   = 32'hAABBCCDD,
    parameter logic [14:0] LFSR_SEED = 15'h7FFF
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  n,
    input  logic [15:0] prbs_len,
    output logic [7:0]  out,
    output logic        data_valid,
    output logic        busy,
    output logic        done
);

    gen_state_e  r_state;
    logic [1:0]  r_byte_idx;
    logic [7:0]  r_rep_cnt;
    logic [7:0]  r_n_q;
    logic [15:0] r_prbs_cnt;
    logic [15:0] r_len_q;

    logic        w_accept;
    logic        w_last_sync;
    logic        w_last_prbs;
    logic        w_step8;
    logic [7:0]  w_prbs_byte;

    function automatic logic [7:0] pattern_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = PATTERN[31:24];
            2'd1:    b = PATTERN[23:16];
            2'd2:    b = PATTERN[15:8];
            default: b = PATTERN[7:0];
        endcase
        return b;
    endfunction

    assign w_accept    = (r_state == IDLE) && start && !abort;
    assign w_last_sync = (r_byte_idx == 2'd3) && (r_rep_cnt == r_n_q - 8'd1);
    assign w_last_prbs = (r_prbs_cnt == r_len_q - 16'd1);
    // Advance whenever a PRBS byte is latched into out this edge.
    assign w_step8     = !abort &&
                         ((w_accept && (n == '0) && (prbs_len != '0)) ||
                          ((r_state == SYNC) && w_last_sync && (r_len_q != '0)) ||
                          ((r_state == PRBS) && !w_last_prbs));

    prbs15_lfsr #(.LFSR_SEED(LFSR_SEED)) u_lfsr (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .i_load  (w_accept),
        .i_step8 (w_step8),
        .o_byte  (w_prbs_byte)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= IDLE;
            r_byte_idx <= '0;
            r_rep_cnt  <= '0;
            r_n_q      <= '0;
            r_prbs_cnt <= '0;
            r_len_q    <= '0;
            out        <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (abort) begin
            r_state    <= IDLE;
            out        <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    out        <= '0;
                    data_valid <= 1'b0;
                    done       <= 1'b0;
                    if (start) begin
                        r_n_q      <= n;
                        r_len_q    <= prbs_len;
                        r_byte_idx <= '0;
                        r_rep_cnt  <= '0;
                        r_prbs_cnt <= '0;
                        busy       <= 1'b1;
                        if (n != '0) begin
                            r_state    <= SYNC;
                            out        <= pattern_byte(2'd0);
                            data_valid <= 1'b1;
                        end else if (prbs_len != '0) begin
                            r_state    <= PRBS;
                            out        <= w_prbs_byte;
                            data_valid <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            done    <= 1'b1;
                        end
                    end
                end
                SYNC: begin
                    if (w_last_sync) begin
                        if (r_len_q != '0) begin
                            r_state    <= PRBS;
                            r_prbs_cnt <= '0;
                            out        <= w_prbs_byte;
                        end else begin
                            r_state    <= DONE;
                            out        <= '0;
                            data_valid <= 1'b0;
                            done       <= 1'b1;
                        end
                    end else begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_rep_cnt <= r_rep_cnt + 8'd1;
                        end
                        out <= pattern_byte(r_byte_idx + 2'd1);
                    end
                end
                PRBS: begin
                    if (w_last_prbs) begin
                        r_state    <= DONE;
                        out        <= '0;
                        data_valid <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        r_prbs_cnt <= r_prbs_cnt + 16'd1;
                        out        <= w_prbs_byte;
                    end
                end
                DONE: begin
                    r_state    <= IDLE;
                    out        <= '0;
                    data_valid <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_prbs_generator.sv
// Self-checking bench: a per-cycle expectation queue built from whole-burst
// descriptions, compared against the DUT on every falling edge.
module tb_pattern_prbs_generator;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        start;
    logic        abort;
    logic [7:0]  n;
    logic [15:0] prbs_len;
    logic [7:0]  out;
    logic        data_valid;
    logic        busy;
    logic        done;

    localparam logic [31:0] PAT = 32'hAABBCCDD;

    pattern_prbs_generator #(
        .PATTERN   (32'hAABBCCDD),
        .LFSR_SEED (15'h7FFF)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .start      (start),
        .abort      (abort),
        .n          (n),
        .prbs_len   (prbs_len),
        .out        (out),
        .data_valid (data_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] b;
        logic       dv;
        logic       bsy;
        logic       dn;
    } rec_t;

    rec_t       exp_q[$];
    logic [7:0] seen[$];
    int         compared   = 0;
    int         mismatched = 0;
    int         done_cnt   = 0;
    logic       cur_busy   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, want, $time);
        end
    endtask

    // Whole-burst expectation: pattern bytes, then serial PRBS-15 bytes from the seed, then done.
    task automatic push_burst(input int unsigned nn, input int unsigned ll);
        int unsigned s;
        int unsigned fb;
        int unsigned v;
        s = 32'h7FFF;
        for (int unsigned r = 0; r < nn; r++)
            for (int unsigned k = 0; k < 4; k++)
                exp_q.push_back('{b: 8'((PAT >> (24 - 8 * k)) & 32'hFF), dv: 1'b1, bsy: 1'b1, dn: 1'b0});
        for (int unsigned i = 0; i < ll; i++) begin
            v = 0;
            for (int unsigned k = 0; k < 8; k++) begin
                fb = ((s >> 14) ^ (s >> 13)) & 1;
                s  = ((s << 1) | fb) & 32'h7FFF;
                v  = (v << 1) | fb;
            end
            exp_q.push_back('{b: 8'(v), dv: 1'b1, bsy: 1'b1, dn: 1'b0});
        end
        exp_q.push_back('{b: 8'h00, dv: 1'b0, bsy: 1'b1, dn: 1'b1});
    endtask

    // Drive one cycle of inputs, advance the model, then compare at the falling edge.
    task automatic step(input logic s, input logic a, input logic [7:0] nn, input logic [15:0] ll);
        rec_t e;
        start    = s;
        abort    = a;
        n        = nn;
        prbs_len = ll;
        if (a) exp_q.delete();
        else if (s && !cur_busy) push_burst(nn, ll);
        @(posedge CLK);
        @(negedge CLK);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = '{b: 8'h00, dv: 1'b0, bsy: 1'b0, dn: 1'b0};
        cur_busy = e.bsy;
        chk("out", 32'(out), 32'(e.b));
        chk("data_valid", 32'(data_valid), 32'(e.dv));
        chk("busy", 32'(busy), 32'(e.bsy));
        chk("done", 32'(done), 32'(e.dn));
        if (data_valid === 1'b1) seen.push_back(out);
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic idle(input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++) step(1'b0, 1'b0, 8'd0, 16'd0);
    endtask

    task automatic clear_log();
        seen.delete();
        done_cnt = 0;
    endtask

    initial begin
        logic [7:0] sync2[8];
        sync2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        RSTn = 1'b0; start = 1'b0; abort = 1'b0; n = '0; prbs_len = '0;
        repeat (3) @(negedge CLK);
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_dv", 32'(data_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        RSTn = 1'b1;
        idle(2);

        // Two pattern repetitions, no payload.
        clear_log();
        step(1'b1, 1'b0, 8'd2, 16'd0);
        idle(10);
        chk("n2_count", 32'(seen.size()), 32'd8);
        for (int i = 0; i < 8 && i < seen.size(); i++) chk("n2_byte", 32'(seen[i]), 32'(sync2[i]));
        chk("n2_done", 32'(done_cnt), 32'd1);

        // Payload only: first two PRBS-15 bytes from seed 7FFF.
        clear_log();
        step(1'b1, 1'b0, 8'd0, 16'd2);
        idle(4);
        chk("p2_count", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            chk("p2_byte0", 32'(seen[0]), 32'h00);
            chk("p2_byte1", 32'(seen[1]), 32'h02);
        end
        chk("p2_done", 32'(done_cnt), 32'd1);

        // Empty burst.
        clear_log();
        step(1'b1, 1'b0, 8'd0, 16'd0);
        idle(3);
        chk("empty_count", 32'(seen.size()), 32'd0);
        chk("empty_done", 32'(done_cnt), 32'd1);

        // Long burst; input changes mid-burst must not matter.
        clear_log();
        step(1'b1, 1'b0, 8'd3, 16'd1000);
        for (int i = 0; i < 1016; i++)
            step(1'b0, 1'b0, 8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));
        chk("long_count", 32'(seen.size()), 32'd1012);
        chk("long_done", 32'(done_cnt), 32'd1);

        // Abort on the 6th valid byte, then a clean restart from the seed.
        clear_log();
        step(1'b1, 1'b0, 8'd4, 16'd5);
        for (int i = 0; i < 20 && seen.size() < 6; i++) step(1'b0, 1'b0, 8'd4, 16'd5);
        chk("abort_reach6", 32'(seen.size()), 32'd6);
        step(1'b0, 1'b1, 8'd4, 16'd5);
        chk("abort_dv", 32'(data_valid), 32'h0);
        idle(4);
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        clear_log();
        step(1'b1, 1'b0, 8'd4, 16'd5);
        idle(25);
        chk("restart_count", 32'(seen.size()), 32'd21);
        if (seen.size() > 0) chk("restart_first", 32'(seen[0]), 32'hAA);
        chk("restart_done", 32'(done_cnt), 32'd1);

        // Abort and start together in IDLE: start dropped.
        clear_log();
        step(1'b1, 1'b1, 8'd1, 16'd1);
        idle(3);
        chk("abort_start_count", 32'(seen.size()), 32'd0);

        // Start held high across a burst: exactly one follow-on burst.
        clear_log();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'd1, 16'd3);
        idle(12);
        chk("held_done", 32'(done_cnt), 32'd2);
        chk("held_count", 32'(seen.size()), 32'd14);

        // Asynchronous reset in the middle of the payload.
        clear_log();
        step(1'b1, 1'b0, 8'd1, 16'd50);
        idle(10);
        start = 1'b0; abort = 1'b0;
        #2 RSTn = 1'b0;
        #1;
        chk("arst_out", 32'(out), 32'h0);
        chk("arst_dv", 32'(data_valid), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        exp_q.delete();
        cur_busy = 1'b0;
        idle(2);
        clear_log();
        step(1'b1, 1'b0, 8'd1, 16'd4);
        idle(10);
        chk("post_rst_count", 32'(seen.size()), 32'd8);

        // Randomized traffic.
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 40) == 0),
                 8'($urandom_range(0, 4)), 16'($urandom_range(0, 12)));
        idle(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pattern_prbs_generator.md
Name: pattern_prbs_generator

Overview:
- Stimulus source that feeds the pattern detector stage downstream.
- On a start request it emits a framed byte stream: the 32-bit sync PATTERN repeated n times, MSB byte first, then prbs_len PRBS-15 payload bytes.
- data_valid stays contiguous high for the whole burst, so the detector sees uninterrupted back-to-back patterns.

Parameters:
- PATTERN, 32'hAABBCCDD, sync word; byte order [31:24],[23:16],[15:8],[7:0].
- LFSR_SEED, 15'h7FFF, PRBS-15 register value reloaded at every accepted start; must be non-zero.

Ports:
- CLK  input  1  clock, rising edge.
- RSTn  input  1  asynchronous, active-low reset.
- start  input  1  burst request; sampled only in IDLE.
- abort  input  1  synchronous burst cancel; priority over all else except RSTn.
- n  input  8  number of PATTERN repetitions; latched at start.
- prbs_len  input  16  number of PRBS bytes; latched at start.
- out  output  8  stream byte, registered.
- data_valid  output  1  out is valid this cycle.
- busy  output  1  high from the cycle after start accepted until DONE exits.
- done  output  1  one-cycle pulse after the last byte.

Behaviour:
- Reset, async on RSTn low:
  - state=IDLE; out=8'h00; data_valid=0; busy=0; done=0.
  - Counters cleared; lfsr=LFSR_SEED.
- States:
  - IDLE, SYNC, PRBS, DONE.
  - Internal counters: byte_idx[1:0], rep_cnt[7:0], prbs_cnt[15:0].
- IDLE:
  - start=1 at edge k latches n_q/len_q, reloads lfsr=LFSR_SEED, clears counters.
  - If n!=0: go to SYNC and present PATTERN[31:24] with data_valid=1 at edge k, i.e. valid in the cycle after start.
  - If n==0 and prbs_len!=0: go to PRBS; the first PRBS byte is presented at edge k.
  - If both are 0: go to DONE; no valid byte is emitted.
- SYNC:
  - Each cycle presents the next PATTERN byte.
  - byte_idx wraps 3->0 and increments rep_cnt.
  - After byte 3 of repetition n_q-1: go to PRBS if len_q!=0, else to DONE.
  - No bubble between repetitions or at the SYNC->PRBS boundary.
- PRBS:
  - Each byte is 8 serial LFSR steps, MSB first. Per step: fb=lfsr[14]^lfsr[13]; lfsr<={lfsr[13:0],fb}; the emitted bit is fb.
  - The byte is computed combinationally from the current lfsr, and lfsr advances 8 steps per emitted byte.
  - After len_q bytes, go to DONE.
- DONE:
  - data_valid=0, out=8'h00, done=1 for exactly one cycle, then IDLE.
  - busy=0 on entering IDLE.
- Outside a burst: data_valid=0 and out=8'h00 whenever not emitting.
- Latency and length:
  - First valid byte appears 1 cycle after start is sampled.
  - Burst length is exactly 4*n_q+len_q valid cycles.
- start while not IDLE: ignored; n/prbs_len changes mid-burst have no effect.
- abort=1 in any state:
  - Next edge: IDLE, data_valid=0, out=0, busy=0.
  - No done pulse.
  - lfsr is not reloaded until the next start.
- abort and start in the same IDLE cycle: abort wins; the start is dropped.
- Counter widths: rep_cnt 8-bit, compared against n_q-1 only when n_q!=0. prbs_cnt 16-bit allows 65535 bytes, with no overflow path.
- RSTn assertion mid-burst: immediate return to the reset values above, regardless of clock.

Decomposition:
- Shared package prbs_pkg holds:
  - the state typedef gen_state_e (IDLE, SYNC, PRBS, DONE);
  - PRBS15 tap constants (taps 14 and 13);
  - a function prbs15_byte(lfsr) returning {next_lfsr, byte}, which the checker side also reuses.
- One sub-module: prbs15_lfsr. It holds the 15-bit register with load (seed) and step8 (advance one byte) controls, and outputs the current byte.

Test Plan:
- n=2, prbs_len=0, start pulse:
  - out=AA,BB,CC,DD,AA,BB,CC,DD on 8 consecutive valid cycles starting 1 cycle after start.
  - Then done=1 for 1 cycle; busy falls with done.
- n=0, prbs_len=2, seed 7FFF:
  - out=8'h00 then 8'h02 with data_valid=1.
  - done on the 3rd cycle after start.
- n=0, prbs_len=0:
  - data_valid never asserts; done=1 exactly 1 cycle after start; busy=1 for that cycle only.
- n=3, prbs_len=1000, downstream detector with n=3:
  - pattern_detected asserts.
  - Valid count is 1012; PRBS bytes match the prbs15_byte reference model.
- abort asserted on the 6th valid byte of an n=4 burst:
  - data_valid=0 from the next cycle; no done.
  - A new start then reproduces the identical sequence from AA, with the seed reloaded.
- RSTn pulse mid-PRBS, and start held high during busy:
  - Reset: all outputs 0 asynchronously.
  - Held start: ignored until IDLE, then exactly one new burst.
